ram_dp_be: RTL and testbench

Parametrised two-port synchronous RAM with per-byte write enables, a configurable read-during-write policy and an optional output pipeline register. Port A is a read/write port for the data-side master. Port B is a read-only port for a second master, such as a debug or DMA reader. Both ports take a one-cycle strobe per command and return a fixed-latency acknowledge, so either port can issue a command every cycle. An optional power-on clearing engine zeroes the array after reset and holds off both ports until it finishes.

---
 rtl/ram_dp_be.sv | 158 +++++++++++++++
 tb/tb_ram_dp_be.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// Two-port RAM with byte write enables, selectable read-during-write result and optional output stage.
// Define RAM_DP_BE_CLEAR_EN to build the power-on clearing engine that zeroes the array after reset.
module ram_dp_be #(
  parameter int AW       = 13,
  parameter int DW       = 32,
  parameter int RDW_MODE = 0,
  parameter int OREG     = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW/8-1:0] a_sel,
  input  logic [DW-1:0] a_di,
  output logic          a_ack,
  output logic [DW-1:0] a_do,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_ack,
  output logic [DW-1:0] b_do,
  output logic          rdy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  logic          clrWe;
  logic [AW-1:0] clrAddr;

`ifdef RAM_DP_BE_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic          rdy_q;

  assign cnt_d = cnt_q + 1'b1;

  // rdy goes high on the same edge that writes the last address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == {AW{1'b1}}) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
          end
        end
        RUN:     rdy_q   <= 1'b1;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign clrWe   = (state_q == CLEAR) && !rst;
  assign clrAddr = cnt_q;
  assign rdy     = rdy_q;
`else
  assign clrWe   = 1'b0;
  assign clrAddr = '0;
  assign rdy     = 1'b1;
`endif

  logic          aAccept;
  logic          bAccept;
  logic          aWrite;
  logic [DW-1:0] aOld;
  logic [DW-1:0] bOld;
  logic [DW-1:0] aMerged;
  logic [DW-1:0] aRdData;
  logic [DW-1:0] bRdData;

  assign aAccept = a_req && rdy && !rst;
  assign bAccept = b_req && rdy && !rst;
  assign aWrite  = aAccept && a_we;

  always_comb begin
    aOld    = mem_q[a_addr];
    bOld    = mem_q[b_addr];
    aMerged = aOld;
    for (int i = 0; i < NB; i++) begin
      if (a_sel[i]) aMerged[8*i +: 8] = a_di[8*i +: 8];
    end
    aRdData = (RDW_MODE != 0 && a_we) ? aMerged : aOld;
    bRdData = (RDW_MODE != 0 && aWrite && a_addr == b_addr) ? aMerged : bOld;
  end

  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem_q[clrAddr] <= '0;
    end else if (aWrite) begin
      for (int i = 0; i < NB; i++) begin
        if (a_sel[i]) mem_q[a_addr][8*i +: 8] <= a_di[8*i +: 8];
      end
    end
  end

  logic          aVal1_q;
  logic          bVal1_q;
  logic [DW-1:0] aData1_q;
  logic [DW-1:0] bData1_q;

  // Data registers load only on accept so outputs hold between acks
  always_ff @(posedge clk) begin
    if (rst) begin
      aVal1_q  <= 1'b0;
      bVal1_q  <= 1'b0;
      aData1_q <= '0;
      bData1_q <= '0;
    end else begin
      aVal1_q <= aAccept;
      bVal1_q <= bAccept;
      if (aAccept) aData1_q <= aRdData;
      if (bAccept) bData1_q <= bRdData;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic          aVal2_q;
    logic          bVal2_q;
    logic [DW-1:0] aData2_q;
    logic [DW-1:0] bData2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        aVal2_q  <= 1'b0;
        bVal2_q  <= 1'b0;
        aData2_q <= '0;
        bData2_q <= '0;
      end else begin
        aVal2_q <= aVal1_q;
        bVal2_q <= bVal1_q;
        if (aVal1_q) aData2_q <= aData1_q;
        if (bVal1_q) bData2_q <= bData1_q;
      end
    end

    assign a_ack = aVal2_q;
    assign a_do  = aData2_q;
    assign b_ack = bVal2_q;
    assign b_do  = bData2_q;
  end else begin : g_noreg
    assign a_ack = aVal1_q;
    assign a_do  = aData1_q;
    assign b_ack = bVal1_q;
    assign b_do  = bData1_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: instance 0 is RDW_MODE=0/OREG=0, instance 1 is RDW_MODE=1/OREG=1.
// Honours RAM_DP_BE_CLEAR_EN the same way the design does.
module tb_ram_dp_be;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic        a_we;
  logic [3:0]  a_addr;
  logic [3:0]  a_sel;
  logic [31:0] a_di;
  logic        b_req;
  logic [3:0]  b_addr;

  logic        a_ack0, b_ack0, rdy0;
  logic [31:0] a_do0, b_do0;
  logic        a_ack1, b_ack1, rdy1;
  logic [31:0] a_do1, b_do1;

  int checks = 0;
  int errors = 0;

  ram_dp_be #(.AW(4), .DW(32), .RDW_MODE(0), .OREG(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_sel(a_sel), .a_di(a_di),
    .a_ack(a_ack0), .a_do(a_do0),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack0), .b_do(b_do0),
    .rdy(rdy0)
  );

  ram_dp_be #(.AW(4), .DW(32), .RDW_MODE(1), .OREG(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_sel(a_sel), .a_di(a_di),
    .a_ack(a_ack1), .a_do(a_do1),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack1), .b_do(b_do1),
    .rdy(rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one port-A command at a falling edge and returns half a cycle after its accept edge
  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [3:0] sel,
                               input logic [31:0] di);
    a_req = 1'b1; a_we = we; a_addr = addr; a_sel = sel; a_di = di;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic test_reset;
    logic expRdy;
`ifdef RAM_DP_BE_CLEAR_EN
    expRdy = 1'b0;
`else
    expRdy = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ack0, b_ack0, a_ack1, b_ack1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_acks got %b expected 0000", {a_ack0, b_ack0, a_ack1, b_ack1});
    end
    checks++;
    if (a_do0 !== 32'h0 || b_do0 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_do0 got %h/%h expected 0/0", a_do0, b_do0);
    end
    checks++;
    if (a_do1 !== 32'h0 || b_do1 !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_do1 got %h/%h expected 0/0", a_do1, b_do1);
    end
    checks++;
    if (rdy0 !== expRdy || rdy1 !== expRdy) begin
      errors++; $display("[TB] FAIL reset_rdy got %b/%b expected %b", rdy0, rdy1, expRdy);
    end
  endtask

`ifdef RAM_DP_BE_CLEAR_EN
  task automatic test_clear;
    int   rise0 = 0;
    int   rise1 = 0;
    logic ackSeen = 1'b0;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      a_req = 1'b0;
      if (a_ack0 || a_ack1) ackSeen = 1'b1;
      if (rdy0 && rise0 == 0) rise0 = n;
      if (rdy1 && rise1 == 0) rise1 = n;
    end
    checks++;
    if (rise0 != 16 || rise1 != 16) begin
      errors++; $display("[TB] FAIL clear_rdy_rise got %0d/%0d expected 16", rise0, rise1);
    end
    checks++;
    if (ackSeen !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_early_strobe got ack %b expected 0", ackSeen);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'(i), 4'h0, 32'h0);
      checks++;
      if (a_ack0 !== 1'b1 || a_do0 !== 32'h0) begin
        errors++; $display("[TB] FAIL clear_read0 addr %0d got %b/%h expected 1/0", i, a_ack0, a_do0);
      end
      @(negedge clk);
      checks++;
      if (a_ack1 !== 1'b1 || a_do1 !== 32'h0) begin
        errors++; $display("[TB] FAIL clear_read1 addr %0d got %b/%h expected 1/0", i, a_ack1, a_do1);
      end
    end
  endtask
`else
  task automatic test_no_macro;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_sel = 4'hF; a_di = 32'h5A5A5A5A;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("[TB] FAIL nomacro_rdy_a got %b/%b expected 1", rdy0, rdy1);
    end
    a_we = 1'b0;
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_ack0 !== 1'b1 || a_do0 !== 32'h5A5A5A5A) begin
      errors++; $display("[TB] FAIL nomacro_read0 got %b/%h expected 1/5a5a5a5a", a_ack0, a_do0);
    end
    @(negedge clk);
    checks++;
    if (a_ack1 !== 1'b1 || a_do1 !== 32'h5A5A5A5A) begin
      errors++; $display("[TB] FAIL nomacro_read1 got %b/%h expected 1/5a5a5a5a", a_ack1, a_do1);
    end
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      errors++; $display("[TB] FAIL nomacro_rdy_b got %b/%b expected 1", rdy0, rdy1);
    end
  endtask
`endif

  task automatic test_byte_merge;
    applyStimulus(1'b1, 4'd3, 4'hF, 32'h11223344);
    checks++;
    if (a_ack0 !== 1'b1 || a_ack1 !== 1'b0) begin
      errors++; $display("[TB] FAIL merge_lat_first got %b/%b expected 1/0", a_ack0, a_ack1);
    end
    @(negedge clk);
    checks++;
    if (a_ack0 !== 1'b0 || a_ack1 !== 1'b1) begin
      errors++; $display("[TB] FAIL merge_lat_second got %b/%b expected 0/1", a_ack0, a_ack1);
    end
    applyStimulus(1'b1, 4'd3, 4'b0101, 32'hAABBCCDD);
    checks++;
    if (a_do0 !== 32'h11223344) begin
      errors++; $display("[TB] FAIL merge_wr_old got %h expected 11223344", a_do0);
    end
    @(negedge clk);
    checks++;
    if (a_do1 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL merge_wr_new got %h expected 11bb33dd", a_do1);
    end
    applyStimulus(1'b0, 4'd3, 4'h0, 32'h0);
    checks++;
    if (a_ack0 !== 1'b1 || a_do0 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL merge_read0 got %b/%h expected 1/11bb33dd", a_ack0, a_do0);
    end
    @(negedge clk);
    checks++;
    if (a_ack1 !== 1'b1 || a_do1 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL merge_read1 got %b/%h expected 1/11bb33dd", a_ack1, a_do1);
    end
    b_req = 1'b1; b_addr = 4'd3;
    @(negedge clk);
    b_req = 1'b0;
    checks++;
    if (b_ack0 !== 1'b1 || b_do0 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL portb_read0 got %b/%h expected 1/11bb33dd", b_ack0, b_do0);
    end
    @(negedge clk);
    checks++;
    if (b_ack1 !== 1'b1 || b_do1 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL portb_read1 got %b/%h expected 1/11bb33dd", b_ack1, b_do1);
    end
  endtask

  task automatic test_back_to_back;
    a_req = 1'b1; a_we = 1'b1; a_sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      a_addr = 4'(i); a_di = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    a_req = 1'b0; a_we = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a_req = (i < 3); a_addr = 4'(i);
      @(negedge clk);
      checks++;
      if (a_ack0 !== (i < 3) || (i < 3 && a_do0 !== 32'hA0 + 32'(i))) begin
        errors++; $display("[TB] FAIL b2b_dut0 slot %0d got %b/%h expected %b/%h", i, a_ack0, a_do0, (i < 3), 32'hA0 + 32'(i));
      end
      checks++;
      if (a_ack1 !== (i >= 1 && i <= 3) || (i >= 1 && i <= 3 && a_do1 !== 32'h9F + 32'(i))) begin
        errors++; $display("[TB] FAIL b2b_dut1 slot %0d got %b/%h expected %b/%h", i, a_ack1, a_do1, (i >= 1 && i <= 3), 32'h9F + 32'(i));
      end
    end
    a_req = 1'b0;
  endtask

  task automatic test_collision;
    applyStimulus(1'b1, 4'd7, 4'hF, 32'h0);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_sel = 4'hF; a_di = 32'hFFFFFFFF;
    b_req = 1'b1; b_addr = 4'd7;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0;
    checks++;
    if (a_ack0 !== 1'b1 || a_do0 !== 32'h0) begin
      errors++; $display("[TB] FAIL coll_a_old got %b/%h expected 1/00000000", a_ack0, a_do0);
    end
    checks++;
    if (b_ack0 !== 1'b1 || b_do0 !== 32'h0) begin
      errors++; $display("[TB] FAIL coll_b_old got %b/%h expected 1/00000000", b_ack0, b_do0);
    end
    @(negedge clk);
    checks++;
    if (a_ack1 !== 1'b1 || a_do1 !== 32'hFFFFFFFF) begin
      errors++; $display("[TB] FAIL coll_a_new got %b/%h expected 1/ffffffff", a_ack1, a_do1);
    end
    checks++;
    if (b_ack1 !== 1'b1 || b_do1 !== 32'hFFFFFFFF) begin
      errors++; $display("[TB] FAIL coll_b_new got %b/%h expected 1/ffffffff", b_ack1, b_do1);
    end
  endtask

  task automatic test_reset_midflight;
    logic ackSeen = 1'b0;
    int   rise = 0;
    int   expRise;
`ifdef RAM_DP_BE_CLEAR_EN
    expRise = 16;
`else
    expRise = 1;
`endif
    applyStimulus(1'b0, 4'd3, 4'h0, 32'h0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (a_ack1) ackSeen = 1'b1;
    end
    checks++;
    if (a_do1 !== 32'h0 || a_do0 !== 32'h0 || a_ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs got %h/%h/%b expected 0/0/0", a_do1, a_do0, a_ack0);
    end
    rst = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (a_ack1) ackSeen = 1'b1;
      if (rdy1 && rise == 0) rise = n;
    end
    checks++;
    if (ackSeen !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_no_ack got %b expected 0", ackSeen);
    end
    checks++;
    if (rise != expRise) begin
      errors++; $display("[TB] FAIL midrst_rdy_rise got %0d expected %0d", rise, expRise);
    end
  endtask

  initial begin
    rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_sel = '0; a_di = '0;
    b_req = 1'b0; b_addr = '0;
    test_reset;
`ifdef RAM_DP_BE_CLEAR_EN
    test_clear;
`else
    test_no_macro;
`endif
    test_byte_merge;
    test_back_to_back;
    test_collision;
    test_reset_midflight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] timeout");
  end

endmodule
